// File: rtl/rng_address.sv
// rng_address_out = rng[RNG_BITS-1:0] mod betterNeighborCount by restoring division, one bit per clock; done pulses RNG_BITS edges after start is sampled.
// start is only accepted in IDLE (no queuing); optional busy output when RNG_ADDRESS_BUSY_EN is defined.
module rng_address #(
  parameter int WIDTH    = 16,
  parameter int RNG_BITS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_rng_address,
  input  logic [WIDTH-1:0] betterNeighborCount,
  input  logic [WIDTH-1:0] rng_out_4bit,
  output logic [WIDTH-1:0] rng_address_out,
  output logic             done_rng_address
`ifdef RNG_ADDRESS_BUSY_EN
  ,
  output logic             busy
`endif
);

  localparam int SW = (RNG_BITS > 1) ? $clog2(RNG_BITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [RNG_BITS-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0]    divisor_q, divisor_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [SW-1:0]       step_q, step_d;
  logic [WIDTH-1:0]    out_d;
  logic                done_d;
  logic [WIDTH:0]      trial;
  logic [WIDTH:0]      diff;
  logic [WIDTH-1:0]    rem_next;
  logic                unused_bits;

  // Only the low RNG_BITS of the random input and the low WIDTH bits of the difference matter.
  assign unused_bits = ^{rng_out_4bit, diff[WIDTH]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      dividend_q       <= '0;
      divisor_q        <= '0;
      rem_q            <= '0;
      step_q           <= '0;
      rng_address_out  <= '0;
      done_rng_address <= 1'b0;
    end else begin
      state_q          <= state_d;
      dividend_q       <= dividend_d;
      divisor_q        <= divisor_d;
      rem_q            <= rem_d;
      step_q           <= step_d;
      rng_address_out  <= out_d;
      done_rng_address <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    step_d     = step_q;
    out_d      = rng_address_out;
    done_d     = 1'b0;
    // Partial remainder is kept below the divisor, so the shifted trial fits in WIDTH+1 bits.
    trial      = {rem_q, dividend_q[step_q]};
    diff       = trial - {1'b0, divisor_q};
    rem_next   = (trial >= {1'b0, divisor_q}) ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

    case (state_q)
      IDLE: begin
        if (start_rng_address) begin
          dividend_d = rng_out_4bit[RNG_BITS-1:0];
          divisor_d  = betterNeighborCount;
          rem_d      = '0;
          step_d     = SW'(RNG_BITS - 1);
          state_d    = CALC;
        end
      end
      CALC: begin
        rem_d = rem_next;
        if (step_q == '0) begin
          // A zero divisor lets the remainder track the dividend; the result is defined as 0.
          out_d   = (divisor_q == '0) ? '0 : rem_next;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          step_d = step_q - SW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef RNG_ADDRESS_BUSY_EN
  assign busy = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_rng_address.sv
// Directed and random checks of rng_address against an arithmetic modulo model.
module tb_rng_address;
  localparam int WIDTH    = 16;
  localparam int RNG_BITS = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] count = '0;
  logic [WIDTH-1:0] rng   = '0;
  logic [WIDTH-1:0] out;
  logic             done;
`ifdef RNG_ADDRESS_BUSY_EN
  logic             busy;
`endif

  int checks = 0;
  int errors = 0;

  rng_address #(.WIDTH(WIDTH), .RNG_BITS(RNG_BITS)) dut (
    .clock               (clock),
    .reset               (reset),
    .start_rng_address   (start),
    .betterNeighborCount (count),
    .rng_out_4bit        (rng),
    .rng_address_out     (out),
    .done_rng_address    (done)
`ifdef RNG_ADDRESS_BUSY_EN
    ,
    .busy                (busy)
`endif
  );

  always #10 clock = ~clock;

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] r);
    int d;
    d = int'(r) % (1 << RNG_BITS);
    if (c == '0) return '0;
    return WIDTH'(d % int'(c));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation from IDLE: latency, result, hold and pulse width; inputs are scrambled after capture.
  task automatic run_op(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] r, input string tag);
    int lat;
    logic [WIDTH-1:0] exp;
    exp = model(c, r);
    @(negedge clock);
    start = 1'b1;
    count = c;
    rng   = r;
    @(posedge clock);
    #1;
    start = 1'b0;
    count = WIDTH'($urandom);
    rng   = WIDTH'($urandom);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (done) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_latency"}, lat, RNG_BITS + 1);
    if (lat != 0) begin
      chk({tag, "_out"}, out, exp);
`ifdef RNG_ADDRESS_BUSY_EN
      chk({tag, "_busy"}, busy, 1'b1);
`endif
      @(negedge clock);
      chk({tag, "_done_width"}, done, 1'b0);
      chk({tag, "_hold"}, out, exp);
    end
  endtask

  initial begin
    int p;
    int seen;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] r;

    #15;
    chk("reset_out", out, 0);
    chk("reset_done", done, 0);
`ifdef RNG_ADDRESS_BUSY_EN
    chk("reset_busy", busy, 0);
`endif
    #10;
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_out", out, 0);
    chk("post_reset_done", done, 0);

    run_op(16'd2, 16'd13, "c2_r13");
    run_op(16'd5, 16'd13, "c5_r13");
    run_op(16'd20, 16'd9, "c20_r9");
    run_op(16'd4, 16'hFFF3, "c4_upper_ignored");
    run_op(16'd0, 16'd7, "c0_r7");
    run_op(16'd1, 16'd15, "c1_r15");
    run_op(16'd15, 16'd14, "c15_r14");

    // Start held high: back-to-back results at a fixed period.
    @(negedge clock);
    count = 16'd2;
    rng   = 16'd13;
    start = 1'b1;
    seen = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (done) begin
        seen = n;
        break;
      end
    end
    chk("b2b_first_seen", (seen != 0), 1'b1);
    chk("b2b_first_out", out, 16'd1);
    p = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (done) begin
        p = n;
        break;
      end
    end
    chk("b2b_period", p, RNG_BITS + 2);
    chk("b2b_second_out", out, 16'd1);
    start = 1'b0;

    // Reset during CALC aborts the operation.
    run_op(16'd5, 16'd13, "pre_abort");
    @(negedge clock);
    count = 16'd5;
    rng   = 16'd13;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_out", out, 0);
    chk("abort_done", done, 0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (done) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_out_after", out, 0);
    run_op(16'd5, 16'd13, "after_abort");

    for (int i = 0; i < 40; i++) begin
      c = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 20));
      r = WIDTH'($urandom);
      run_op(c, r, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
